// File: rtl/pkt_flit_buffer_if.sv
// rtl/pkt_flit_buffer_if.sv - writer/reader bundle for the speculative packet flit buffer
interface pkt_flit_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
);
  localparam int CNTW = $clog2(DEPTH + 1);

  // writer side
  logic                  wr_valid;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ack;
  logic                  wr_drop;
  logic [CNTW-1:0]       capacity;

  // reader side
  logic                  rd_next;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_last;
  logic [CNTW-1:0]       pkt_count;

  modport master (
    output wr_valid, wr_data, rd_next,
    input  wr_ack, wr_drop, capacity, rd_data, rd_valid, rd_last, pkt_count
  );

  modport slave (
    input  wr_valid, wr_data, rd_next,
    output wr_ack, wr_drop, capacity, rd_data, rd_valid, rd_last, pkt_count
  );
endinterface

// File: rtl/pkt_flit_buffer.sv
// rtl/pkt_flit_buffer.sv - circular flit buffer with speculative packet commit and rollback
//
// Flits of a packet are written behind commit_tail and only become visible to
// the reader once the last flit arrives. A bad flit number or running out of
// space rolls wr_tail back to commit_tail, discarding the partial packet.
// Each stored slot carries an extra "last" bit above the flit data.
module pkt_flit_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int CW         = 3,
  parameter int FN_LSB     = 0,
  parameter int PS_LSB     = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  pkt_flit_buffer_if.slave bus
);
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int MW   = DATA_WIDTH + 1;

  // storage: {last, data}; intentionally not cleared by reset
  logic [MW-1:0]   r_mem [DEPTH];

  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_commit_tail;
  logic [PW-1:0]   r_wr_tail;
  logic [CNTW-1:0] r_cnt_c;
  logic [CNTW-1:0] r_cnt_s;
  logic [CNTW-1:0] r_pkt_count;
  logic [CW-1:0]   r_expected;
  logic [CW-1:0]   r_size;
  logic            r_wr_ack;
  logic            r_wr_drop;

  logic [CW-1:0]   w_fn;
  logic [CW-1:0]   w_ps;
  logic [CW-1:0]   w_exp_inc;
  logic [CW-1:0]   w_size_eff;
  logic [CNTW-1:0] w_free;
  logic [CNTW-1:0] w_cnt_c_add;
  logic            w_fn_bad;
  logic            w_hdr_bad;
  logic            w_full;
  logic            w_accept;
  logic            w_rollback;
  logic            w_drop;
  logic            w_last;
  logic            w_commit;
  logic            w_rd_fire;
  logic            w_head_last;
  logic [PW-1:0]   w_wr_tail_inc;
  logic [PW-1:0]   w_head_inc;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_fn       = bus.wr_data[FN_LSB +: CW];
  assign w_ps       = bus.wr_data[PS_LSB +: CW];
  assign w_exp_inc  = r_expected + CW'(1);

  // free space is taken from registered counts, so a same-cycle read never
  // makes room for a same-cycle write
  assign w_free     = CNTW'(DEPTH) - r_cnt_c - r_cnt_s;

  // write decision, in priority order: flit number, header sanity, space
  assign w_fn_bad   = bus.wr_valid && (w_fn != r_expected);
  assign w_hdr_bad  = bus.wr_valid && !w_fn_bad && (r_expected == '0) &&
                      ((w_ps == '0) || (32'(w_ps) > 32'(DEPTH)));
  assign w_full     = bus.wr_valid && !w_fn_bad && !w_hdr_bad && (w_free == '0);
  assign w_accept   = bus.wr_valid && !w_fn_bad && !w_hdr_bad && !w_full;
  assign w_rollback = w_fn_bad || w_full;
  assign w_drop     = w_fn_bad || w_hdr_bad || w_full;

  // on flit 0 the size comes straight from the header, later from the latch
  assign w_size_eff = (r_expected == '0) ? w_ps : r_size;
  assign w_last     = (w_exp_inc == w_size_eff);
  assign w_commit   = w_accept && w_last;

  assign w_wr_tail_inc = ptr_inc(r_wr_tail);
  assign w_head_inc    = ptr_inc(r_head);

  assign w_rd_fire   = bus.rd_next && (r_cnt_c != '0);
  assign w_head_last = r_mem[r_head][DATA_WIDTH];
  assign w_cnt_c_add = w_commit ? (r_cnt_s + CNTW'(1)) : '0;

  // flit storage; a held reset suppresses writes so nothing lands mid-reset
  always_ff @(posedge clock) begin
    if (reset_n && w_accept) begin
      r_mem[r_wr_tail] <= {w_last, bus.wr_data};
    end
  end

  // write-side pointers, speculative count and packet tracking
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_wr_tail     <= '0;
      r_commit_tail <= '0;
      r_cnt_s       <= '0;
      r_expected    <= '0;
      r_size        <= '0;
    end else if (w_rollback) begin
      r_wr_tail     <= r_commit_tail;
      r_cnt_s       <= '0;
      r_expected    <= '0;
    end else if (w_accept) begin
      r_wr_tail <= w_wr_tail_inc;
      if (r_expected == '0) begin
        r_size <= w_ps;
      end
      if (w_last) begin
        r_commit_tail <= w_wr_tail_inc;
        r_cnt_s       <= '0;
        r_expected    <= '0;
      end else begin
        r_cnt_s    <= r_cnt_s + CNTW'(1);
        r_expected <= w_exp_inc;
      end
    end
  end

  // committed side: head pointer, committed flits and whole-packet count
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_head      <= '0;
      r_cnt_c     <= '0;
      r_pkt_count <= '0;
    end else begin
      if (w_rd_fire) begin
        r_head <= w_head_inc;
      end
      r_cnt_c     <= r_cnt_c + w_cnt_c_add - CNTW'(w_rd_fire);
      r_pkt_count <= r_pkt_count + CNTW'(w_commit) - CNTW'(w_rd_fire && w_head_last);
    end
  end

  // one-cycle status pulses for the writer
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_wr_ack  <= 1'b0;
      r_wr_drop <= 1'b0;
    end else begin
      r_wr_ack  <= w_commit;
      r_wr_drop <= w_drop;
    end
  end

  assign bus.wr_ack    = r_wr_ack;
  assign bus.wr_drop   = r_wr_drop;
  assign bus.capacity  = w_free;
  assign bus.rd_valid  = (r_cnt_c != '0);
  assign bus.rd_data   = r_mem[r_head][DATA_WIDTH-1:0];
  // the last bit of a stale slot must not leak out while the buffer is empty
  assign bus.rd_last   = (r_cnt_c != '0) && w_head_last;
  assign bus.pkt_count = r_pkt_count;
endmodule

// File: tb/tb_pkt_flit_buffer.sv
// tb/tb_pkt_flit_buffer.sv - self-checking bench for pkt_flit_buffer
module tb_pkt_flit_buffer;
  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pkt_flit_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus8 ();
  pkt_flit_buffer_if #(.DATA_WIDTH(DW), .DEPTH(4))     bus4 ();

  pkt_flit_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CW(3), .FN_LSB(0), .PS_LSB(4)) u_dut8 (
    .clock(clk), .reset_n(reset_n), .bus(bus8)
  );
  pkt_flit_buffer #(.DATA_WIDTH(DW), .DEPTH(4), .CW(3), .FN_LSB(0), .PS_LSB(4)) u_dut4 (
    .clock(clk), .reset_n(reset_n), .bus(bus4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: committed flits and the partial packet as queues of {last, data}
  logic [32:0] mc[$];
  logic [32:0] ms[$];
  int   m_exp;
  int   m_size;
  logic m_ack;
  logic m_drop;

  typedef struct {
    logic        wv;
    logic [31:0] wd;
    logic        rn;
    logic        ack;
    logic        drop;
    int          cap;
    logic        rv;
    logic        rl;
    int          pkt;
    logic [31:0] rdata;
  } vec_t;
  vec_t vt[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int m_pkts();
    int c = 0;
    foreach (mc[i]) if (mc[i][32]) c++;
    return c;
  endfunction

  task automatic model_reset();
    mc.delete();
    ms.delete();
    m_exp  = 0;
    m_size = 0;
    m_ack  = 1'b0;
    m_drop = 1'b0;
  endtask

  task automatic model_step(input logic wv, input logic [31:0] wd, input logic rn);
    int free;
    int fn;
    int ps;
    bit commit;
    free   = DEPTH - mc.size() - ms.size();
    commit = 0;
    m_ack  = 1'b0;
    m_drop = 1'b0;
    if (wv) begin
      fn = int'(wd[2:0]);
      ps = int'(wd[6:4]);
      if (fn != m_exp) begin
        ms.delete(); m_exp = 0; m_drop = 1'b1;
      end else if (m_exp == 0 && (ps == 0 || ps > DEPTH)) begin
        m_drop = 1'b1;
      end else if (free == 0) begin
        ms.delete(); m_exp = 0; m_drop = 1'b1;
      end else begin
        if (m_exp == 0) m_size = ps;
        ms.push_back({(m_exp + 1 == m_size), wd});
        m_exp++;
        if (m_exp == m_size) begin
          commit = 1; m_exp = 0; m_ack = 1'b1;
        end
      end
    end
    if (rn && mc.size() > 0) void'(mc.pop_front());
    if (commit) begin
      foreach (ms[i]) mc.push_back(ms[i]);
      ms.delete();
    end
  endtask

  task automatic check_model();
    chk("m_wr_ack", 32'(bus8.wr_ack), 32'(m_ack));
    chk("m_wr_drop", 32'(bus8.wr_drop), 32'(m_drop));
    chk("m_capacity", 32'(bus8.capacity), DEPTH - mc.size() - ms.size());
    chk("m_rd_valid", 32'(bus8.rd_valid), 32'(mc.size() != 0));
    chk("m_pkt_count", 32'(bus8.pkt_count), m_pkts());
    if (mc.size() != 0) begin
      chk("m_rd_data", bus8.rd_data, mc[0][31:0]);
      chk("m_rd_last", 32'(bus8.rd_last), 32'(mc[0][32]));
    end else begin
      chk("m_rd_last", 32'(bus8.rd_last), 32'd0);
    end
  endtask

  task automatic apply(input logic wv, input logic [31:0] wd, input logic rn);
    bus8.wr_valid = wv;
    bus8.wr_data  = wd;
    bus8.rd_next  = rn;
    @(posedge clk);
    model_step(wv, wd, rn);
    #1;
    check_model();
  endtask

  task automatic do_reset(input logic wv, input logic [31:0] wd);
    reset_n       = 1'b0;
    bus8.wr_valid = wv;
    bus8.wr_data  = wd;
    bus8.rd_next  = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    chk("rst_ack", 32'(bus8.wr_ack), 32'd0);
    chk("rst_drop", 32'(bus8.wr_drop), 32'd0);
    chk("rst_cap", 32'(bus8.capacity), 32'd8);
    chk("rst_rd_valid", 32'(bus8.rd_valid), 32'd0);
    chk("rst_rd_last", 32'(bus8.rd_last), 32'd0);
    chk("rst_pkt", 32'(bus8.pkt_count), 32'd0);
    reset_n       = 1'b1;
    bus8.wr_valid = 1'b0;
  endtask

  task automatic step4(input logic wv, input logic [31:0] wd);
    bus4.wr_valid = wv;
    bus4.wr_data  = wd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int g_idx;
    int g_ps;
    int fn;
    logic wv;
    logic rn;
    logic [31:0] d;

    // hand-derived vectors: packet of 3, bad flit number rollback, size-0 header
    vt[0]  = '{1'b1, 32'h30, 1'b0, 1'b0, 1'b0, 7, 1'b0, 1'b0, 0, 32'h0};
    vt[1]  = '{1'b1, 32'h31, 1'b0, 1'b0, 1'b0, 6, 1'b0, 1'b0, 0, 32'h0};
    vt[2]  = '{1'b1, 32'h32, 1'b0, 1'b1, 1'b0, 5, 1'b1, 1'b0, 1, 32'h30};
    vt[3]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 6, 1'b1, 1'b0, 1, 32'h31};
    vt[4]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 7, 1'b1, 1'b1, 1, 32'h32};
    vt[5]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 8, 1'b0, 1'b0, 0, 32'h0};
    vt[6]  = '{1'b1, 32'h30, 1'b0, 1'b0, 1'b0, 7, 1'b0, 1'b0, 0, 32'h0};
    vt[7]  = '{1'b1, 32'h31, 1'b0, 1'b0, 1'b0, 6, 1'b0, 1'b0, 0, 32'h0};
    vt[8]  = '{1'b1, 32'h33, 1'b0, 1'b0, 1'b1, 8, 1'b0, 1'b0, 0, 32'h0};
    vt[9]  = '{1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 7, 1'b0, 1'b0, 0, 32'h0};
    vt[10] = '{1'b1, 32'h21, 1'b0, 1'b1, 1'b0, 6, 1'b1, 1'b0, 1, 32'h20};
    vt[11] = '{1'b1, 32'h00, 1'b0, 1'b0, 1'b1, 6, 1'b1, 1'b0, 1, 32'h20};
    vt[12] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 7, 1'b1, 1'b1, 1, 32'h21};
    vt[13] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 8, 1'b0, 1'b0, 0, 32'h0};

    bus8.wr_valid = 1'b0; bus8.wr_data = '0; bus8.rd_next = 1'b0;
    bus4.wr_valid = 1'b0; bus4.wr_data = '0; bus4.rd_next = 1'b0;
    model_reset();
    @(posedge clk); #1;
    do_reset(1'b0, 32'h0);

    // DEPTH=4: oversized header dropped, size-4 packet fills it exactly
    step4(1'b1, 32'h50);
    chk("d4_hdr_drop", 32'(bus4.wr_drop), 32'd1);
    chk("d4_hdr_cap", 32'(bus4.capacity), 32'd4);
    step4(1'b1, 32'h40);
    step4(1'b1, 32'h41);
    step4(1'b1, 32'h42);
    chk("d4_cap1", 32'(bus4.capacity), 32'd1);
    chk("d4_no_ack", 32'(bus4.wr_ack), 32'd0);
    step4(1'b1, 32'h43);
    chk("d4_ack", 32'(bus4.wr_ack), 32'd1);
    chk("d4_cap0", 32'(bus4.capacity), 32'd0);
    chk("d4_pkt", 32'(bus4.pkt_count), 32'd1);
    chk("d4_rd_data", bus4.rd_data, 32'h40);
    step4(1'b0, 32'h0);
    chk("d4_ack_once", 32'(bus4.wr_ack), 32'd0);

    for (int i = 0; i < 14; i++) begin
      apply(vt[i].wv, vt[i].wd, vt[i].rn);
      chk($sformatf("v%0d_ack", i), 32'(bus8.wr_ack), 32'(vt[i].ack));
      chk($sformatf("v%0d_drop", i), 32'(bus8.wr_drop), 32'(vt[i].drop));
      chk($sformatf("v%0d_cap", i), 32'(bus8.capacity), vt[i].cap);
      chk($sformatf("v%0d_rv", i), 32'(bus8.rd_valid), 32'(vt[i].rv));
      chk($sformatf("v%0d_rl", i), 32'(bus8.rd_last), 32'(vt[i].rl));
      chk($sformatf("v%0d_pkt", i), 32'(bus8.pkt_count), vt[i].pkt);
      if (vt[i].rv) chk($sformatf("v%0d_rdata", i), bus8.rd_data, vt[i].rdata);
    end

    // overflow rollback: 7-flit packet, then a 2-flit packet that runs out of room
    for (int k = 0; k < 7; k++) apply(1'b1, 32'h70 + 32'(k), 1'b0);
    chk("t4_cap1", 32'(bus8.capacity), 32'd1);
    apply(1'b1, 32'h20, 1'b0);
    chk("t4_cap0", 32'(bus8.capacity), 32'd0);
    apply(1'b1, 32'h21, 1'b0);
    chk("t4_drop", 32'(bus8.wr_drop), 32'd1);
    chk("t4_cap_back", 32'(bus8.capacity), 32'd1);
    chk("t4_pkt", 32'(bus8.pkt_count), 32'd1);
    chk("t4_head", bus8.rd_data, 32'h70);

    // full buffer with same-cycle read: space is sampled before the read
    apply(1'b1, 32'h10, 1'b0);
    chk("t5_fill_ack", 32'(bus8.wr_ack), 32'd1);
    chk("t5_full", 32'(bus8.capacity), 32'd0);
    apply(1'b1, 32'h10, 1'b1);
    chk("t5_drop", 32'(bus8.wr_drop), 32'd1);
    chk("t5_cap_after_rd", 32'(bus8.capacity), 32'd1);
    chk("t5_head_adv", bus8.rd_data, 32'h71);
    apply(1'b1, 32'h10, 1'b0);
    chk("t5_retry_ack", 32'(bus8.wr_ack), 32'd1);
    chk("t5_retry_pkt", 32'(bus8.pkt_count), 32'd3);

    // reset while a packet is in flight and committed packets are queued
    apply(1'b0, 32'h0, 1'b1);
    apply(1'b1, 32'h20, 1'b0);
    chk("t6_spec_cap", 32'(bus8.capacity), 32'd0);
    do_reset(1'b1, 32'h21);
    apply(1'b1, 32'h10, 1'b0);
    chk("t6_ack", 32'(bus8.wr_ack), 32'd1);
    chk("t6_pkt", 32'(bus8.pkt_count), 32'd1);
    chk("t6_rdata", bus8.rd_data, 32'h10);
    chk("t6_rlast", 32'(bus8.rd_last), 32'd1);
    chk("t6_cap", 32'(bus8.capacity), 32'd7);
    apply(1'b0, 32'h0, 1'b1);

    // randomized traffic, mostly well-formed packets with occasional corruption
    g_idx = 0;
    g_ps  = 0;
    for (int i = 0; i < 3000; i++) begin
      wv = ($urandom_range(0, 9) < 7);
      rn = ($urandom_range(0, 9) < 5);
      d  = $urandom;
      if (g_idx == 0) g_ps = $urandom_range(0, 7);
      fn = g_idx;
      if ($urandom_range(0, 19) == 0) fn = $urandom_range(0, 7);
      d[2:0] = 3'(fn);
      if (g_idx == 0) d[6:4] = 3'(g_ps);
      if (wv) g_idx = (g_idx + 1 < g_ps) ? g_idx + 1 : 0;
      apply(wv, d, rn);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
